seven_segment_capture: RTL
==========================

// Module: seven_segment_capture
// PURPOSE
//  Receive side of the 4-digit multiplexed seven-segment bus (anode[3:0] + segment[7:0], both active-low).
//  Samples the scanned bus, rejects transition ghosting and decodes each lit glyph back to a digit value and DP flag.
//  Rebuilds the 4 displayed digits. Sits in the Memory-Game self-check path and is used as a board-level display monitor.
// PARAMETERS
//  SYNC_STAGES    2  flops on each bus input before use (>=1)
//  STABLE_CYCLES  4  consecutive identical samples required before commit (>=2)
// PORTS
//  src_clk      in   1   sole clock; all logic on its posedge
//  src_rst_n    in   1   asynchronous, active-low reset
//  clear        in   1   synchronous clear of captured state
//  anode        in   4   scanned anode lines; one-hot-low selects a digit, 4'b1111 = blank
//  segment      in   8   cathodes: [7]=DP, [6:0]=G..A, all active-low
//  digits       out  16  digit k in [4k+3:4k]
//  dps          out  4   dps[k]=1 -> DP lit on digit k
//  digit_valid  out  4   digit k holds a successfully decoded glyph
//  pattern_err  out  1   1-cycle pulse: committed glyph not in table
//  anode_err    out  1   1-cycle pulse: committed anode neither one-hot-low nor blank
//  frame_done   out  1   1-cycle pulse: all 4 positions committed since last pulse
// BEHAVIOUR
//  - Reset (async assert): digits=0, dps=0, digit_valid=0, all pulses 0, seen=0.
//    Candidate = {4'b1111,8'hFF}; state HELD. Synchronizer flops reset to 1 (idle bus).
//  - Sample s = {anode,segment} after SYNC_STAGES flops. Candidate FSM, one state per edge:
//    TRACK: s!=cand -> cand<=s, cnt<=0. s==cand -> cnt<=cnt+1.
//           When cnt becomes STABLE_CYCLES-1, COMMIT on that edge -> HELD.
//    HELD:  s==cand -> stay, no further commits. s!=cand -> cand<=s, cnt<=0, TRACK.
//  - Latency: bus stable from before edge 1 -> outputs updated after edge SYNC_STAGES+STABLE_CYCLES (6 at defaults).
//  - Pulses are high only in the cycle following the commit edge.
//  - COMMIT actions by cand anode:
//    1111: no update, no error, seen unchanged.
//    one-hot-low, position k: dps[k]<=~seg[7]; glyph = seg[6:0] decoded.
//      Glyph table: 40=0 79=1 24=2 30=3 19=4 12=5 02=6 78=7 00=8 18=9.
//      Hit: digits[k]<=value, digit_valid[k]<=1.
//      Miss: digits[k] held, digit_valid[k]<=0, pattern_err pulse.
//      seen[k]<=1 on hit or miss.
//    any other anode: anode_err pulse; nothing else changes.
//  - frame_done: when a commit makes seen==4'b1111, pulse frame_done and seen<=0 on the same edge.
//    Repeat commits to an already-seen position only update data.
//  - clear (sync, below reset): same values as reset except the synchronizer.
//    clear wins over a same-cycle commit; no pulses that cycle.
//  - Counter width $clog2(STABLE_CYCLES); it saturates in HELD and never wraps.
//  - Async reset mid-frame discards partial frame and candidate; recapture restarts from the next stable sample.
// STRUCTURE
//  - Package seven_seg_pkg: SEG_0..SEG_9 active-low 7-bit glyph constants, SEG_DP_BIT=7, ANODE_BLANK=4'hF.
//    Also holds the capture FSM state typedef {TRACK,HELD}.
//  - One sub-module: seven_segment_glyph_decode (comb: seg[6:0] -> value[3:0], hit). Shared with future display checks.
//  - Synchronizer and FSM inline.
// TESTING (SYNC_STAGES=2, STABLE_CYCLES=4)
//  1. Reset, drive idle bus -> all outputs 0; no pulse ever with anode=1111.
//  2. anode=1101, seg=A4 held -> after edge 6: digits[7:4]=2, digit_valid=0010, dps=0000.
//  3. anode=1110/seg=F9 held only 3 cycles, then 1111 -> no commit, outputs unchanged.
//  4. anode=1110, seg=FF held -> one pattern_err pulse, digit_valid[0]=0, digits[3:0] unchanged.
//     Then anode=1100 held -> one anode_err pulse only.
//  5. Scan 1110:C0, 1101:F9, 1011:A4, 0111:30, 8 cycles each -> digits=16'h3210, dps=1000, digit_valid=1111.
//     Exactly one frame_done, after 4th commit.
//  6. Assert clear in the commit cycle of test 2 -> no update, no pulse. Deassert src_rst_n mid-scan -> outputs 0 immediately.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Glyphs are active-low on segment[6:0] = G..A.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;

    localparam int         SEG_DP_BIT  = 7;
    localparam logic [3:0] ANODE_BLANK = 4'hF;

    // TRACK: candidate still settling. HELD: candidate committed (or idle after reset).
    typedef enum logic {
        TRACK = 1'b0,
        HELD  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational glyph decoder: active-low 7-segment pattern to digit value.
// hit=0 means the pattern is not one of the ten digit glyphs; value is 0 then.
module seven_segment_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       hit
);

    // Table lookup; unknown patterns fall through to a miss.
    always_comb begin
        value = 4'd0;
        hit   = 1'b1;
        case (seg)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a 4-digit multiplexed seven-segment bus.
// The bus is synchronized, a sample must stay identical for STABLE_CYCLES
// edges before it is committed (this rejects scan ghosting), and each
// committed glyph is decoded into the digit register for its anode.
module seven_segment_capture
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        src_clk,
    input  logic        src_rst_n,
    input  logic        clear,
    input  logic [3:0]  anode,
    input  logic [7:0]  segment,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  digit_valid,
    output logic        pattern_err,
    output logic        anode_err,
    output logic        frame_done
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    // Commit fires on the edge where the counter would reach STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [11:0] IDLE_BUS = {ANODE_BLANK, 8'hFF};

    // ---------------- synchronizer ----------------
    logic [11:0] sync_q [SYNC_STAGES];
    logic [11:0] s;

    // Shift the raw bus through SYNC_STAGES flops; reset to the idle bus value.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_BUS;
        end else begin
            sync_q[0] <= {anode, segment};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ---------------- candidate FSM ----------------
    cap_state_t       state_q, state_d;
    logic [11:0]      cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    // State register; clear returns the FSM to its reset values.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_q <= HELD;
            cand_q  <= IDLE_BUS;
            cnt_q   <= '0;
        end else if (clear) begin
            state_q <= HELD;
            cand_q  <= IDLE_BUS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: restart on any change, count matches, commit once then hold.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            TRACK: begin
                if (s != cand_q) begin
                    cand_d = s;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_PRE) begin
                        commit  = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                // Counter is left untouched here, so it saturates.
                if (s != cand_q) begin
                    cand_d  = s;
                    cnt_d   = '0;
                    state_d = TRACK;
                end
            end
            default: state_d = HELD;
        endcase
    end

    // ---------------- commit datapath ----------------
    logic [3:0] cand_anode;
    logic [7:0] cand_seg;
    logic [3:0] glyph_value;
    logic       glyph_hit;
    logic [1:0] pos;
    logic       anode_blank;
    logic       anode_onehot;

    assign cand_anode   = cand_q[11:8];
    assign cand_seg     = cand_q[7:0];
    assign anode_blank  = (cand_anode == ANODE_BLANK);
    assign anode_onehot = $onehot(~cand_anode);

    seven_segment_glyph_decode u_decode (
        .seg   (cand_seg[6:0]),
        .value (glyph_value),
        .hit   (glyph_hit)
    );

    // Digit position of the single low anode line.
    always_comb begin
        pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cand_anode[i]) pos = 2'(i);
        end
    end

    logic [15:0] digits_d;
    logic [3:0]  dps_d, valid_d, seen_q, seen_d, seen_nxt;
    logic        perr_d, aerr_d, fdone_d;

    // Commit actions: update the addressed digit, track seen positions, raise pulses.
    always_comb begin
        digits_d = digits;
        dps_d    = dps;
        valid_d  = digit_valid;
        seen_d   = seen_q;
        seen_nxt = seen_q;
        perr_d   = 1'b0;
        aerr_d   = 1'b0;
        fdone_d  = 1'b0;
        if (commit && !anode_blank) begin
            if (anode_onehot) begin
                dps_d[pos] = ~cand_seg[SEG_DP_BIT];
                if (glyph_hit) begin
                    digits_d[{pos, 2'b00} +: 4] = glyph_value;
                    valid_d[pos] = 1'b1;
                end else begin
                    valid_d[pos] = 1'b0;
                    perr_d       = 1'b1;
                end
                seen_nxt      = seen_q;
                seen_nxt[pos] = 1'b1;
                if (seen_nxt == 4'hF) begin
                    fdone_d = 1'b1;
                    seen_d  = 4'h0;
                end else begin
                    seen_d = seen_nxt;
                end
            end else begin
                aerr_d = 1'b1;
            end
        end
    end

    // Output registers; clear wins over a same-cycle commit and suppresses pulses.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            digits      <= '0;
            dps         <= '0;
            digit_valid <= '0;
            seen_q      <= '0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            frame_done  <= 1'b0;
        end else if (clear) begin
            digits      <= '0;
            dps         <= '0;
            digit_valid <= '0;
            seen_q      <= '0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            digits      <= digits_d;
            dps         <= dps_d;
            digit_valid <= valid_d;
            seen_q      <= seen_d;
            pattern_err <= perr_d;
            anode_err   <= aerr_d;
            frame_done  <= fdone_d;
        end
    end

endmodule
